// File: rtl/dataflow_deadlock_monitor_if.sv
// Signal bundle between a dataflow chain observer and the deadlock monitor.
// Suffixes are from the monitor's point of view.
//   enable_i, clear_i            : monitoring control
//   blk_wr_i, blk_rd_i, proc_idle_i : per-process status flags
//   deadlock_o .. stall_cnt_o    : latched report and live persistence counter
// master = the side that drives the status flags, slave = the monitor.
interface dataflow_deadlock_monitor_if #(
   parameter int N_PROC = 3,
   parameter int CNT_W  = 8,
   parameter int IDX_W  = 2
);
   logic                enable_i;
   logic                clear_i;
   logic [N_PROC-1:0]   blk_wr_i;
   logic [N_PROC-1:0]   blk_rd_i;
   logic [N_PROC-1:0]   proc_idle_i;
   logic                deadlock_o;
   logic                detect_pulse_o;
   logic [1:0]          dl_kind_o;
   logic [IDX_W-1:0]    dl_origin_o;
   logic [N_PROC-1:0]   dl_snap_wr_o;
   logic [N_PROC-1:0]   dl_snap_rd_o;
   logic [CNT_W-1:0]    stall_cnt_o;

   modport master (
      output enable_i, clear_i, blk_wr_i, blk_rd_i, proc_idle_i,
      input  deadlock_o, detect_pulse_o, dl_kind_o, dl_origin_o,
             dl_snap_wr_o, dl_snap_rd_o, stall_cnt_o
   );

   modport slave (
      input  enable_i, clear_i, blk_wr_i, blk_rd_i, proc_idle_i,
      output deadlock_o, detect_pulse_o, dl_kind_o, dl_origin_o,
             dl_snap_wr_o, dl_snap_rd_o, stall_cnt_o
   );
endinterface

// File: rtl/dataflow_deadlock_monitor.sv
// Deadlock monitor for an N_PROC-process linear dataflow chain. Observes
// per-process blocked/idle flags, detects adjacent mutual waits and
// whole-chain stalls, and latches a sticky report once a condition has
// persisted unchanged for TIMEOUT cycles. Purely an observer.
// Ports: clk_i (rising edge), rst_ni (async, active-low), mon_if (slave
// modport: control/status inputs, report outputs).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no candidate condition in the samples
// SUSPECT   | candidate seen, counting cycles it stays unchanged
// DETECTED  | report latched; held until clear or reset
module dataflow_deadlock_monitor #(
   parameter int N_PROC    = 3,
   parameter int TIMEOUT   = 16,
   parameter int CNT_W     = 8,
   parameter int IDX_W     = 2,
   parameter int GLOBAL_EN = 1
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   dataflow_deadlock_monitor_if.slave mon_if
);
   typedef enum logic [1:0] {ST_IDLE, ST_SUSPECT, ST_DETECTED} state_t;

   state_t              state_q, state_d;
   logic [N_PROC-1:0]   s_wr_q, s_rd_q, s_idle_q;
   logic [N_PROC-1:0]   cand_q, cand_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                dl_q, dl_d;
   logic                pulse_q, pulse_d;
   logic [1:0]          kind_q, kind_d;
   logic [IDX_W-1:0]    origin_q, origin_d;
   logic [N_PROC-1:0]   snap_wr_q, snap_wr_d;
   logic [N_PROC-1:0]   snap_rd_q, snap_rd_d;

   logic [N_PROC-1:0]   cand;
   logic [IDX_W-1:0]    origin_calc;
   logic [CNT_W-1:0]    cnt_inc;

   // Idle processes never count as blocked; the global bit needs at least
   // one busy process and every process either idle or blocked.
   always_comb begin
      cand = '0;
      for (int i = 0; i < N_PROC-1; i++) begin
         cand[i] = s_wr_q[i] & s_rd_q[i+1] & ~s_idle_q[i] & ~s_idle_q[i+1];
      end
      cand[N_PROC-1] = (GLOBAL_EN != 0) & (|(~s_idle_q)) & (&(s_idle_q | s_wr_q | s_rd_q));
   end

   // Lowest pair wins; global-only reports point past the last pair.
   always_comb begin
      origin_calc = IDX_W'(N_PROC-1);
      for (int i = N_PROC-2; i >= 0; i--) begin
         if (cand[i]) origin_calc = IDX_W'(i);
      end
   end

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      dl_d      = dl_q;
      pulse_d   = 1'b0;
      kind_d    = kind_q;
      origin_d  = origin_q;
      snap_wr_d = snap_wr_q;
      snap_rd_d = snap_rd_q;
      if (mon_if.clear_i) begin
         state_d   = ST_IDLE;
         cand_d    = '0;
         cnt_d     = '0;
         dl_d      = 1'b0;
         kind_d    = '0;
         origin_d  = '0;
         snap_wr_d = '0;
         snap_rd_d = '0;
      end else if (!mon_if.enable_i) begin
         if (state_q != ST_DETECTED) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cand != '0) begin
                  state_d = ST_SUSPECT;
                  cnt_d   = CNT_W'(1);
                  cand_d  = cand;
               end
            end
            ST_SUSPECT: begin
               if (cand == '0) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cand != cand_q) begin
                  cnt_d  = CNT_W'(1);
                  cand_d = cand;
               end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                  state_d   = ST_DETECTED;
                  cnt_d     = cnt_inc;
                  dl_d      = 1'b1;
                  pulse_d   = 1'b1;
                  kind_d    = {cand[N_PROC-1], |cand[N_PROC-2:0]};
                  origin_d  = origin_calc;
                  snap_wr_d = s_wr_q;
                  snap_rd_d = s_rd_q;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_DETECTED: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         s_wr_q    <= '0;
         s_rd_q    <= '0;
         s_idle_q  <= '0;
         cand_q    <= '0;
         cnt_q     <= '0;
         dl_q      <= 1'b0;
         pulse_q   <= 1'b0;
         kind_q    <= '0;
         origin_q  <= '0;
         snap_wr_q <= '0;
         snap_rd_q <= '0;
      end else begin
         state_q   <= state_d;
         s_wr_q    <= mon_if.blk_wr_i;
         s_rd_q    <= mon_if.blk_rd_i;
         s_idle_q  <= mon_if.proc_idle_i;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         dl_q      <= dl_d;
         pulse_q   <= pulse_d;
         kind_q    <= kind_d;
         origin_q  <= origin_d;
         snap_wr_q <= snap_wr_d;
         snap_rd_q <= snap_rd_d;
      end
   end

   assign mon_if.deadlock_o     = dl_q;
   assign mon_if.detect_pulse_o = pulse_q;
   assign mon_if.dl_kind_o      = kind_q;
   assign mon_if.dl_origin_o    = origin_q;
   assign mon_if.dl_snap_wr_o   = snap_wr_q;
   assign mon_if.dl_snap_rd_o   = snap_rd_q;
   assign mon_if.stall_cnt_o    = cnt_q;
endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
module tb_dataflow_deadlock_monitor;
   localparam int N_PROC = 3;
   localparam int TIMEOUT = 4;
   localparam int CNT_W = 8;
   localparam int IDX_W = 2;

   typedef struct {
      logic [CNT_W-1:0]  cnt;
      logic              dl;
      logic              pl;
      logic [1:0]        kind;
      logic [IDX_W-1:0]  org;
      logic [N_PROC-1:0] swr;
      logic [N_PROC-1:0] srd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   dataflow_deadlock_monitor_if #(.N_PROC(N_PROC), .CNT_W(CNT_W), .IDX_W(IDX_W)) mon_if ();

   dataflow_deadlock_monitor #(
      .N_PROC(N_PROC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .IDX_W(IDX_W), .GLOBAL_EN(1)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .mon_if (mon_if)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(int cnt, bit dl, bit pl, int kind, int org, int swr, int srd);
      exp_t e;
      e.cnt  = CNT_W'(cnt);
      e.dl   = dl;
      e.pl   = pl;
      e.kind = 2'(kind);
      e.org  = IDX_W'(org);
      e.swr  = N_PROC'(swr);
      e.srd  = N_PROC'(srd);
      return e;
   endfunction

   function automatic exp_t cn(int cnt);
      return mk(cnt, 1'b0, 1'b0, 0, 0, 0, 0);
   endfunction

   function automatic exp_t rep(bit pl, int kind, int org, int swr, int srd);
      return mk(TIMEOUT, 1'b1, pl, kind, org, swr, srd);
   endfunction

   task automatic cmp(string tag, string fld, logic [31:0] obs, logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, expv);
      end
   endtask

   task automatic check_out(string tag);
      exp_t e;
      e = exp_q.pop_front();
      cmp(tag, "stall_cnt", 32'(mon_if.stall_cnt_o), 32'(e.cnt));
      cmp(tag, "deadlock", 32'(mon_if.deadlock_o), 32'(e.dl));
      cmp(tag, "detect_pulse", 32'(mon_if.detect_pulse_o), 32'(e.pl));
      cmp(tag, "dl_kind", 32'(mon_if.dl_kind_o), 32'(e.kind));
      cmp(tag, "dl_origin", 32'(mon_if.dl_origin_o), 32'(e.org));
      cmp(tag, "dl_snap_wr", 32'(mon_if.dl_snap_wr_o), 32'(e.swr));
      cmp(tag, "dl_snap_rd", 32'(mon_if.dl_snap_rd_o), 32'(e.srd));
   endtask

   // Drive one cycle of inputs, then check outputs just after the edge.
   task automatic step(string tag, logic [2:0] w, logic [2:0] r, logic [2:0] id,
                       logic en, logic clr, exp_t e);
      mon_if.blk_wr_i    = w;
      mon_if.blk_rd_i    = r;
      mon_if.proc_idle_i = id;
      mon_if.enable_i    = en;
      mon_if.clear_i     = clr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   task automatic async_reset(string tag);
      #1 rst_n = 1'b0;
      #1;
      exp_q.push_back(cn(0));
      check_out(tag);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      mon_if.blk_wr_i    = '0;
      mon_if.blk_rd_i    = '0;
      mon_if.proc_idle_i = '0;
      mon_if.enable_i    = 1'b1;
      mon_if.clear_i     = 1'b0;
      #3;
      exp_q.push_back(cn(0));
      check_out("reset");
      @(negedge clk) rst_n = 1'b1;

      // pair 0 deadlock: P0 = wr 001, rd 010
      step("pair_e0", 3'b001, 3'b010, 3'b000, 1, 0, cn(0));
      step("pair_e1", 3'b001, 3'b010, 3'b000, 1, 0, cn(1));
      step("pair_e2", 3'b001, 3'b010, 3'b000, 1, 0, cn(2));
      step("pair_e3", 3'b001, 3'b010, 3'b000, 1, 0, cn(3));
      step("pair_e4", 3'b001, 3'b010, 3'b000, 1, 0, rep(1, 1, 0, 3'b001, 3'b010));
      step("pair_e5", 3'b001, 3'b010, 3'b000, 1, 0, rep(0, 1, 0, 3'b001, 3'b010));
      // sticky with inputs dropped, and with enable low
      step("sticky_a", 3'b000, 3'b000, 3'b000, 1, 0, rep(0, 1, 0, 3'b001, 3'b010));
      step("sticky_b", 3'b000, 3'b000, 3'b000, 1, 0, rep(0, 1, 0, 3'b001, 3'b010));
      step("sticky_en0", 3'b000, 3'b000, 3'b000, 0, 0, rep(0, 1, 0, 3'b001, 3'b010));
      step("clear", 3'b000, 3'b000, 3'b000, 1, 1, cn(0));
      step("post_clear", 3'b000, 3'b000, 3'b000, 1, 0, cn(0));

      // transient: counter 1,2,3 then back to 0
      step("trans_a", 3'b001, 3'b010, 3'b000, 1, 0, cn(0));
      step("trans_b", 3'b001, 3'b010, 3'b000, 1, 0, cn(1));
      step("trans_c", 3'b001, 3'b010, 3'b000, 1, 0, cn(2));
      step("trans_d", 3'b000, 3'b000, 3'b000, 1, 0, cn(3));
      step("trans_e", 3'b000, 3'b000, 3'b000, 1, 0, cn(0));
      step("trans_f", 3'b000, 3'b000, 3'b000, 1, 0, cn(0));

      // global + pair 1: cand = 110 -> kind 11, origin 1
      step("glob1_0", 3'b011, 3'b100, 3'b000, 1, 0, cn(0));
      step("glob1_1", 3'b011, 3'b100, 3'b000, 1, 0, cn(1));
      step("glob1_2", 3'b011, 3'b100, 3'b000, 1, 0, cn(2));
      step("glob1_3", 3'b011, 3'b100, 3'b000, 1, 0, cn(3));
      step("glob1_4", 3'b011, 3'b100, 3'b000, 1, 0, rep(1, 3, 1, 3'b011, 3'b100));
      step("glob1_clr", 3'b000, 3'b000, 3'b000, 1, 1, cn(0));

      // global only: cand = 100 -> kind 10, origin 2
      step("glob2_0", 3'b001, 3'b000, 3'b110, 1, 0, cn(0));
      step("glob2_1", 3'b001, 3'b000, 3'b110, 1, 0, cn(1));
      step("glob2_2", 3'b001, 3'b000, 3'b110, 1, 0, cn(2));
      step("glob2_3", 3'b001, 3'b000, 3'b110, 1, 0, cn(3));
      step("glob2_4", 3'b001, 3'b000, 3'b110, 1, 0, rep(1, 2, 2, 3'b001, 3'b000));
      step("glob2_clr", 3'b000, 3'b000, 3'b000, 1, 1, cn(0));

      // window restart: pair 0 for 2 cycles, then pair 1
      step("win_0", 3'b001, 3'b010, 3'b000, 1, 0, cn(0));
      step("win_1", 3'b001, 3'b010, 3'b000, 1, 0, cn(1));
      step("win_2", 3'b010, 3'b100, 3'b000, 1, 0, cn(2));
      step("win_3", 3'b010, 3'b100, 3'b000, 1, 0, cn(1));
      step("win_4", 3'b010, 3'b100, 3'b000, 1, 0, cn(2));
      step("win_5", 3'b010, 3'b100, 3'b000, 1, 0, cn(3));
      step("win_6", 3'b010, 3'b100, 3'b000, 1, 0, rep(1, 1, 1, 3'b010, 3'b100));
      step("win_clr", 3'b000, 3'b000, 3'b000, 1, 1, cn(0));

      // clear on the detecting edge: no pulse, no report
      step("cd_0", 3'b001, 3'b010, 3'b000, 1, 0, cn(0));
      step("cd_1", 3'b001, 3'b010, 3'b000, 1, 0, cn(1));
      step("cd_2", 3'b001, 3'b010, 3'b000, 1, 0, cn(2));
      step("cd_3", 3'b001, 3'b010, 3'b000, 1, 0, cn(3));
      step("cd_clr", 3'b001, 3'b010, 3'b000, 1, 1, cn(0));
      step("cd_5", 3'b001, 3'b010, 3'b000, 1, 0, cn(1));
      step("cd_6", 3'b000, 3'b000, 3'b000, 1, 0, cn(2));
      step("cd_7", 3'b000, 3'b000, 3'b000, 1, 0, cn(0));

      // enable low keeps the counter at 0
      for (int k = 0; k < 5; k++) begin
         step("en0_hold", 3'b001, 3'b010, 3'b000, 0, 0, cn(0));
      end
      step("en1_a", 3'b001, 3'b010, 3'b000, 1, 0, cn(1));
      step("en0_susp", 3'b000, 3'b000, 3'b000, 0, 0, cn(0));
      step("en1_b", 3'b000, 3'b000, 3'b000, 1, 0, cn(0));

      // async reset during SUSPECT
      step("rs_0", 3'b001, 3'b010, 3'b000, 1, 0, cn(0));
      step("rs_1", 3'b001, 3'b010, 3'b000, 1, 0, cn(1));
      step("rs_2", 3'b001, 3'b010, 3'b000, 1, 0, cn(2));
      async_reset("rst_suspect");
      // async reset during DETECTED
      step("rd_0", 3'b001, 3'b010, 3'b000, 1, 0, cn(0));
      step("rd_1", 3'b001, 3'b010, 3'b000, 1, 0, cn(1));
      step("rd_2", 3'b001, 3'b010, 3'b000, 1, 0, cn(2));
      step("rd_3", 3'b001, 3'b010, 3'b000, 1, 0, cn(3));
      step("rd_4", 3'b001, 3'b010, 3'b000, 1, 0, rep(1, 1, 0, 3'b001, 3'b010));
      async_reset("rst_detected");
      step("rd_after", 3'b000, 3'b000, 3'b000, 1, 0, cn(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
